// File: rtl/tone_combiner.sv
// ---------------------------------------------------------------------------
// tone_combiner
//
// Per-DAC tone summer. NTONE oscillator streams, each NLANE samples wide per
// clock, are gated by a per-tone enable mask, summed through a registered
// pairwise adder tree, scaled by a programmable arithmetic right shift and
// saturated to DW bits.
//
// The enable mask and shift live in shadow registers that load together on
// cfg_stb. A commit also pulses phase_rst (to the dlo phase-reset inputs) and
// mutes dac_out for LAT+1 cycles so that no sample mixing old and new
// configuration reaches the DAC.
//
// Pipeline (LAT = log2(NTONE) + 2 registers, tone_in -> dac_out):
//   stage 0            : register tones, zero disabled tones
//   stages 1..log2(N)  : registered pairwise adder tree
//   final stage        : shift, saturate, mute
//
// Optional build macro:
//   TONE_COMBINER_ROUND_EN  round half up before the shift (shift > 0);
//                           undefined -> floor (truncation).
//
// Ports:
//   clk         DSP clock
//   reset       asynchronous, active-high reset
//   tone_in     tone t, lane l at [(t*NLANE+l)*DW +: DW]; lane 0 is earliest
//   tone_valid  tone_in qualifier
//   en_mask_in  per-tone enable, captured on cfg_stb
//   shift_in    right-shift amount, captured on cfg_stb
//   cfg_stb     one-cycle commit of en_mask_in / shift_in
//   sat_clr     clears sat_flag and sat_count (wins over a new saturation)
//   dac_out     lane l at [l*DW +: DW]
//   dac_valid   tone_valid delayed by LAT
//   phase_rst   one-cycle pulse the cycle after cfg_stb
//   sat_flag    sticky saturation indicator
//   sat_count   count of saturated output cycles, holds at 0xFFFF
// ---------------------------------------------------------------------------
module tone_combiner #(
    parameter int unsigned NTONE  = 8,
    parameter int unsigned NLANE  = 4,
    parameter int unsigned DW     = 16,
    parameter int unsigned SHIFTW = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NTONE*NLANE*DW-1:0] tone_in,
    input  logic                      tone_valid,
    input  logic [NTONE-1:0]          en_mask_in,
    input  logic [SHIFTW-1:0]         shift_in,
    input  logic                      cfg_stb,
    input  logic                      sat_clr,
    output logic [NLANE*DW-1:0]       dac_out,
    output logic                      dac_valid,
    output logic                      phase_rst,
    output logic                      sat_flag,
    output logic [15:0]               sat_count
);

    // -----------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------
    localparam int unsigned LOG2  = $clog2(NTONE);
    // Full-precision tree sum: cannot overflow for NTONE DW-bit operands.
    localparam int unsigned SW    = DW + LOG2;
    // One extra bit so the rounding increment cannot wrap the sum.
    localparam int unsigned RW    = SW + 1;
    localparam int unsigned LAT   = LOG2 + 2;
    // Heap-ordered tree: node i has children 2i+1 and 2i+2, root is node 0,
    // leaves (stage 0) are nodes NTONE-1 .. 2*NTONE-2.
    localparam int unsigned NNODE = 2 * NTONE - 1;
    localparam int unsigned FW    = $clog2(LAT + 2);

    localparam logic [FW-1:0]        FLUSH_LOAD  = FW'(LAT + 1);
    localparam logic [15:0]          SAT_CNT_MAX = 16'hFFFF;
    localparam logic signed [RW-1:0] SAT_MAX     = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN     = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // -----------------------------------------------------------------------
    // Shadowed configuration, phase-reset pulse and flush counter
    // -----------------------------------------------------------------------
    logic [NTONE-1:0]  mask_q;
    logic [SHIFTW-1:0] shift_q;
    logic              phase_q;
    logic [FW-1:0]     flush_q;
    logic [FW-1:0]     flush_d;
    logic              mute;

    always_comb begin
        flush_d = flush_q;
        if (cfg_stb) begin
            flush_d = FLUSH_LOAD;
        end else if (flush_q != '0) begin
            flush_d = flush_q - 1'b1;
        end
    end

    // The output register is muted whenever the counter will be nonzero after
    // this edge, so dac_out reads zero for exactly LAT+1 cycles per commit.
    assign mute = (flush_d != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q  <= '0;
            shift_q <= '0;
            phase_q <= 1'b0;
            flush_q <= '0;
        end else begin
            if (cfg_stb) begin
                mask_q  <= en_mask_in;
                shift_q <= shift_in;
            end
            phase_q <= cfg_stb;
            flush_q <= flush_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 0 and adder tree
    // -----------------------------------------------------------------------
    logic signed [SW-1:0] node_q [NNODE][NLANE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NNODE; i++) begin
                for (int l = 0; l < NLANE; l++) begin
                    node_q[i][l] <= '0;
                end
            end
        end else begin
            // Leaves: sign-extend each enabled tone to tree width.
            for (int t = 0; t < NTONE; t++) begin
                for (int l = 0; l < NLANE; l++) begin
                    if (mask_q[t]) begin
                        node_q[NTONE-1+t][l] <= SW'($signed(tone_in[(t*NLANE+l)*DW +: DW]));
                    end else begin
                        node_q[NTONE-1+t][l] <= '0;
                    end
                end
            end
            // Internal nodes: every level reads the level below from the
            // previous cycle, giving one register per tree level.
            for (int i = 0; i < NTONE - 1; i++) begin
                for (int l = 0; l < NLANE; l++) begin
                    node_q[i][l] <= node_q[2*i+1][l] + node_q[2*i+2][l];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Final stage: round (optional), shift, saturate
    // -----------------------------------------------------------------------
    logic signed [RW-1:0] lane_wide [NLANE];
    logic [NLANE-1:0]     lane_clamp;
    logic [NLANE*DW-1:0]  lane_res;

    always_comb begin
        lane_clamp = '0;
        lane_res   = '0;
        for (int l = 0; l < NLANE; l++) begin
            lane_wide[l] = RW'(node_q[0][l]);
`ifdef TONE_COMBINER_ROUND_EN
            if (shift_q != '0) begin
                lane_wide[l] = lane_wide[l] + (RW'(1) << (shift_q - 1'b1));
            end
`endif
            // Arithmetic shift floors toward -inf; oversize shifts give 0/-1.
            lane_wide[l] = lane_wide[l] >>> shift_q;
            if (lane_wide[l] > SAT_MAX) begin
                lane_clamp[l]          = 1'b1;
                lane_res[l*DW +: DW] = SAT_MAX[DW-1:0];
            end else if (lane_wide[l] < SAT_MIN) begin
                lane_clamp[l]          = 1'b1;
                lane_res[l*DW +: DW] = SAT_MIN[DW-1:0];
            end else begin
                lane_res[l*DW +: DW] = lane_wide[l][DW-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output registers, valid pipeline and saturation accounting
    // -----------------------------------------------------------------------
    logic [LAT-1:0]      vld_q;
    logic [NLANE*DW-1:0] dac_q;
    logic                sat_flag_q;
    logic [15:0]         sat_count_q;
    logic                sat_hit;

    // vld_q[LAT-2] is the valid that becomes dac_valid at this edge, so the
    // count moves in the same cycle the clamped sample appears on dac_out.
    // Muted (forced-zero) samples never count.
    assign sat_hit = vld_q[LAT-2] & ~mute & (|lane_clamp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q       <= '0;
            dac_q       <= '0;
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            vld_q <= {vld_q[LAT-2:0], tone_valid};
            dac_q <= mute ? '0 : lane_res;
            if (sat_clr) begin
                sat_flag_q  <= 1'b0;
                sat_count_q <= '0;
            end else if (sat_hit) begin
                sat_flag_q <= 1'b1;
                if (sat_count_q != SAT_CNT_MAX) begin
                    sat_count_q <= sat_count_q + 16'd1;
                end
            end
        end
    end

    assign dac_out   = dac_q;
    assign dac_valid = vld_q[LAT-1];
    assign phase_rst = phase_q;
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_tone_combiner.sv
// ---------------------------------------------------------------------------
// tb_tone_combiner
// Directed and randomized stimulus for tone_combiner (NTONE=8, NLANE=4,
// DW=16, SHIFTW=4). Every output is compared each cycle against a
// sample-level reference model: per-input masked sums delayed by the
// pipeline latency, floor/round division by 2^shift, clamping, mute window
// after each commit, and a saturating event counter.
// ---------------------------------------------------------------------------
module tb_tone_combiner;

    localparam int unsigned NTONE  = 8;
    localparam int unsigned NLANE  = 4;
    localparam int unsigned DW     = 16;
    localparam int unsigned SHIFTW = 4;
    localparam int          LAT    = 5;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NTONE*NLANE*DW-1:0] tone_in;
    logic                      tone_valid;
    logic [NTONE-1:0]          en_mask_in;
    logic [SHIFTW-1:0]         shift_in;
    logic                      cfg_stb;
    logic                      sat_clr;
    logic [NLANE*DW-1:0]       dac_out;
    logic                      dac_valid;
    logic                      phase_rst;
    logic                      sat_flag;
    logic [15:0]               sat_count;

    tone_combiner #(
        .NTONE  (NTONE),
        .NLANE  (NLANE),
        .DW     (DW),
        .SHIFTW (SHIFTW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tone_in    (tone_in),
        .tone_valid (tone_valid),
        .en_mask_in (en_mask_in),
        .shift_in   (shift_in),
        .cfg_stb    (cfg_stb),
        .sat_clr    (sat_clr),
        .dac_out    (dac_out),
        .dac_valid  (dac_valid),
        .phase_rst  (phase_rst),
        .sat_flag   (sat_flag),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b1;

    // Reference model state
    longint           q_lane [NLANE][$];
    bit               q_vld [$];
    logic [NTONE-1:0] m_mask;
    int               m_shift;
    int               n_edge;
    int               last_stb;
    longint           exp_lane [NLANE];
    bit               exp_valid;
    bit               exp_phase;
    bit               exp_flag;
    int               exp_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // floor(s / 2^sh), or round-half-up when rounding is built in
    function automatic longint scale(input longint s, input int sh);
        longint d;
        longint q;
        longint x;
        d = 1;
        repeat (sh) d = d * 2;
        x = s;
`ifdef TONE_COMBINER_ROUND_EN
        if (sh > 0) x = x + d / 2;
`endif
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NLANE; l++) begin
            q_lane[l].delete();
            for (int k = 0; k < LAT - 1; k++) q_lane[l].push_back(0);
            exp_lane[l] = 0;
        end
        q_vld.delete();
        for (int k = 0; k < LAT - 1; k++) q_vld.push_back(1'b0);
        m_mask    = '0;
        m_shift   = 0;
        n_edge    = 0;
        last_stb  = -100;
        exp_valid = 1'b0;
        exp_phase = 1'b0;
        exp_flag  = 1'b0;
        exp_cnt   = 0;
    endtask

    // One rising edge of the model, using the inputs applied before the edge.
    task automatic model_edge();
        longint ent;
        longint v;
        bit     mute;
        bit     clamp_any;
        if (reset) begin
            model_reset();
        end else begin
            for (int l = 0; l < NLANE; l++) begin
                ent = 0;
                for (int t = 0; t < NTONE; t++) begin
                    if (m_mask[t]) ent += longint'($signed(tone_in[(t*NLANE+l)*DW +: DW]));
                end
                q_lane[l].push_back(ent);
            end
            q_vld.push_back(tone_valid);
            if (cfg_stb) last_stb = n_edge;
            mute      = (n_edge - last_stb) <= LAT;
            clamp_any = 1'b0;
            for (int l = 0; l < NLANE; l++) begin
                v = scale(q_lane[l].pop_front(), m_shift);
                if (v > 32767) begin
                    v = 32767;
                    clamp_any = 1'b1;
                end else if (v < -32768) begin
                    v = -32768;
                    clamp_any = 1'b1;
                end
                exp_lane[l] = mute ? 0 : v;
            end
            exp_valid = q_vld.pop_front();
            exp_phase = cfg_stb;
            if (sat_clr) begin
                exp_cnt  = 0;
                exp_flag = 1'b0;
            end else if (exp_valid && !mute && clamp_any) begin
                exp_flag = 1'b1;
                if (exp_cnt < 65535) exp_cnt++;
            end
            if (cfg_stb) begin
                m_mask  = en_mask_in;
                m_shift = int'(shift_in);
            end
            n_edge++;
        end
    endtask

    task automatic check_all();
        logic [15:0] e16;
        for (int l = 0; l < NLANE; l++) begin
            e16 = 16'(exp_lane[l]);
            check($sformatf("dac_lane%0d", l), {16'h0, dac_out[l*DW +: DW]}, {16'h0, e16});
        end
        check("dac_valid", {31'h0, dac_valid}, {31'h0, exp_valid});
        check("phase_rst", {31'h0, phase_rst}, {31'h0, exp_phase});
        check("sat_flag", {31'h0, sat_flag}, {31'h0, exp_flag});
        check("sat_count", {16'h0, sat_count}, 32'(exp_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (chk_en) check_all();
    endtask

    task automatic set_tone(input int t, input logic [15:0] v);
        for (int l = 0; l < NLANE; l++) tone_in[(t*NLANE+l)*DW +: DW] = v;
    endtask

    task automatic rand_tones();
        for (int i = 0; i < NTONE * NLANE; i++) tone_in[i*DW +: DW] = 16'($urandom);
    endtask

    task automatic commit(input logic [NTONE-1:0] m, input logic [SHIFTW-1:0] s);
        en_mask_in = m;
        shift_in   = s;
        cfg_stb    = 1'b1;
        tick();
        cfg_stb    = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input logic [15:0] v);
        for (int l = 0; l < NLANE; l++) check(tag, {16'h0, dac_out[l*DW +: DW]}, {16'h0, v});
    endtask

    int saved_cnt;

    initial begin
        reset      = 1'b1;
        tone_valid = 1'b0;
        en_mask_in = '0;
        shift_in   = '0;
        cfg_stb    = 1'b0;
        sat_clr    = 1'b0;
        rand_tones();
        model_reset();

        // 1: reset with random tones, then valid data with the reset mask
        repeat (3) begin
            rand_tones();
            tick();
        end
        check("rst_dac", {31'h0, |dac_out}, 32'h0);
        check("rst_valid", {31'h0, dac_valid}, 32'h0);
        check("rst_count", {16'h0, sat_count}, 32'h0);
        reset      = 1'b0;
        tone_valid = 1'b1;
        repeat (8) begin
            rand_tones();
            tick();
        end
        check("nomask_dac", {31'h0, |dac_out}, 32'h0);
        check("nomask_valid", {31'h0, dac_valid}, 32'h1);

        // 2: single tone passes through unchanged
        set_tone(0, 16'd1000);
        for (int t = 1; t < NTONE; t++) set_tone(t, 16'd5000);
        commit(8'h01, 4'd0);
        check("s2_phase_hi", {31'h0, phase_rst}, 32'h1);
        tick();
        check("s2_phase_lo", {31'h0, phase_rst}, 32'h0);
        repeat (7) tick();
        check_lanes("s2_lane", 16'd1000);

        // 3: positive saturation, then rescale out of it
        for (int t = 0; t < NTONE; t++) set_tone(t, 16'd20000);
        commit(8'hFF, 4'd0);
        repeat (8) tick();
        check_lanes("s3_sat_lane", 16'h7FFF);
        check("s3_flag", {31'h0, sat_flag}, 32'h1);
        saved_cnt = exp_cnt;
        tick();
        check("s3_cnt_inc", {16'h0, sat_count}, 32'(saved_cnt + 1));
        saved_cnt = exp_cnt;
        commit(8'hFF, 4'd3);
        repeat (8) tick();
        check_lanes("s3_shift3_lane", 16'd20000);
        check("s3_cnt_hold", {16'h0, sat_count}, 32'(saved_cnt));

        // 4: negative full scale, with and without saturation; floor vs round
        for (int t = 0; t < NTONE; t++) set_tone(t, 16'h8000);
        sat_clr = 1'b1;
        commit(8'hFF, 4'd3);
        sat_clr = 1'b0;
        repeat (8) tick();
        check_lanes("s4_neg_sh3", 16'h8000);
        check("s4_noflag", {31'h0, sat_flag}, 32'h0);
        check("s4_nocnt", {16'h0, sat_count}, 32'h0);
        commit(8'hFF, 4'd2);
        repeat (8) tick();
        check_lanes("s4_neg_sh2", 16'h8000);
        check("s4_flag", {31'h0, sat_flag}, 32'h1);
        check("s4_cnt", {16'h0, sat_count}, 32'd3);
        set_tone(0, 16'd3);
        set_tone(1, 16'hFFFC);
        commit(8'h03, 4'd1);
        repeat (8) tick();
`ifdef TONE_COMBINER_ROUND_EN
        check_lanes("s4_round", 16'h0000);
`else
        check_lanes("s4_floor", 16'hFFFF);
`endif

        // Randomized traffic with occasional commits and clears
        for (int i = 0; i < 150; i++) begin
            rand_tones();
            tone_valid = ($urandom_range(0, 3) != 0);
            sat_clr    = ($urandom_range(0, 24) == 0);
            en_mask_in = NTONE'($urandom);
            shift_in   = SHIFTW'($urandom_range(0, 4));
            cfg_stb    = ($urandom_range(0, 19) == 0);
            tick();
            cfg_stb    = 1'b0;
            sat_clr    = 1'b0;
        end

        // 5: back-to-back commits two cycles apart mid-stream
        tone_valid = 1'b1;
        rand_tones();
        commit(NTONE'($urandom), SHIFTW'($urandom_range(0, 2)));
        check("s5_phase1", {31'h0, phase_rst}, 32'h1);
        rand_tones();
        tone_valid = 1'b0;
        tick();
        check("s5_phase_gap", {31'h0, phase_rst}, 32'h0);
        rand_tones();
        tone_valid = 1'b1;
        commit(8'hFF, 4'd1);
        check("s5_phase2", {31'h0, phase_rst}, 32'h1);
        check("s5_mute0", {31'h0, |dac_out}, 32'h0);
        for (int i = 1; i < 6; i++) begin
            rand_tones();
            tone_valid = ($urandom_range(0, 1) != 0);
            tick();
            check($sformatf("s5_mute%0d", i), {31'h0, |dac_out}, 32'h0);
        end
        repeat (10) begin
            rand_tones();
            tone_valid = ($urandom_range(0, 1) != 0);
            tick();
        end

        // 6: clear during continuous saturation, then saturate the counter
        tone_valid = 1'b1;
        for (int t = 0; t < NTONE; t++) set_tone(t, 16'd20000);
        commit(8'hFF, 4'd0);
        repeat (8) tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("s6_clr", {16'h0, sat_count}, 32'h0);
        check("s6_clr_flag", {31'h0, sat_flag}, 32'h0);
        tick();
        check("s6_after_clr", {16'h0, sat_count}, 32'h1);
        chk_en = 1'b0;
        repeat (65540) tick();
        chk_en = 1'b1;
        tick();
        check("s6_cnt_max", {16'h0, sat_count}, 32'hFFFF);
        tick();
        check("s6_cnt_hold", {16'h0, sat_count}, 32'hFFFF);

        // Asynchronous reset between clock edges
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_dac", {31'h0, |dac_out}, 32'h0);
        check("arst_valid", {31'h0, dac_valid}, 32'h0);
        check("arst_phase", {31'h0, phase_rst}, 32'h0);
        check("arst_flag", {31'h0, sat_flag}, 32'h0);
        check("arst_count", {16'h0, sat_count}, 32'h0);
        tick();
        reset = 1'b0;
        repeat (8) begin
            rand_tones();
            tick();
        end
        check("post_rst_dac", {31'h0, |dac_out}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tone_combiner.md
Name: tone_combiner

Overview:
Parametrised successor to the fixed 8-tone per-DAC summer in the qubic DSP path. It takes NTONE oscillator outputs, each NLANE samples wide per clock, and gates each tone with a per-tone enable. It sums the tones through a registered adder tree, applies a programmable arithmetic right-shift, then saturates the result to DAC width. It sits between the dlo bank and one dsp.dacN bus, and adds a shadowed config commit with phase-reset and flush-mute sequencing.

Parameters:
NTONE, 8, tones summed; power of 2, range 2..32
NLANE, 4, parallel samples per clock (DAC lanes)
DW, 16, sample width, signed two's complement
SHIFTW, 4, width of the scale-shift field

Ports:
clk  in  1  DSP clock
reset  in  1  asynchronous, active-high reset
tone_in  in  NTONE*NLANE*DW  tone t, lane l at bits [(t*NLANE+l)*DW +: DW]; lane 0 is the earliest sample
tone_valid  in  1  tone_in qualifier
en_mask_in  in  NTONE  per-tone enable, captured on cfg_stb
shift_in  in  SHIFTW  right-shift amount, captured on cfg_stb
cfg_stb  in  1  one-cycle commit of en_mask_in and shift_in
sat_clr  in  1  clears sat_flag and sat_count
dac_out  out  NLANE*DW  lane l at [l*DW +: DW]
dac_valid  out  1  dac_out qualifier
phase_rst  out  1  one-cycle pulse to the dlo reset inputs
sat_flag  out  1  sticky: saturation has occurred
sat_count  out  16  count of cycles with saturation; holds at 0xFFFF

Behaviour:
- Reset (asynchronous): all pipeline registers, dac_out, dac_valid, phase_rst, sat_flag, sat_count, flush counter, active mask and active shift go to 0. Reset mid-stream drops all in-flight samples.
- Latency L = log2(NTONE)+2 clocks, tone_in to dac_out (5 for NTONE=8).
  - Stage 0 registers the tones, zeroing disabled tones.
  - Stages 1..log2(NTONE) form a pairwise registered adder tree.
  - The final stage registers the shift and saturation.
- dac_valid is tone_valid delayed by exactly L. Data propagates regardless of valid.
- Arithmetic:
  - Sum width is SW = DW+log2(NTONE); no overflow is possible inside the tree.
  - The shift is arithmetic with floor (truncation). Shift values >= SW produce 0 or -1.
  - Result is clamped to [-2^(DW-1), 2^(DW-1)-1].
- Config commit:
  - On the cycle cfg_stb is high, the active mask and active shift load. They take effect in stage 0 on the next cycle.
  - phase_rst pulses high the cycle after cfg_stb.
  - The flush counter loads L+1. While it is nonzero, dac_out is forced to 0 and dac_valid is unaffected. Forced-zero lanes never count as saturated.
  - cfg_stb during a flush reloads the counter and pulses phase_rst again.
- Saturation:
  - sat_count increments by 1 in any cycle where dac_valid=1, no mute is active, and any lane clamped.
  - sat_flag is set under the same condition.
  - sat_clr wins over a simultaneous saturation: the result is count=0, flag=0.
- With the reset mask of 0, the block outputs all-zero samples until the first commit.

Optional Feature:
TONE_COMBINER_ROUND_EN
- Defined: when shift>0, add 2^(shift-1) to the sum before shifting (round-half-up). The add is absorbed in the final stage, so latency is unchanged, and saturation is applied after rounding.
- Undefined: truncation (floor) as described in Behaviour.

Test Plan:
1. Assert reset for 3 cycles with random tone_in -> dac_out=0, dac_valid=0, phase_rst=0, sat_count=0. Then tone_valid=1 with no commit -> dac_out stays 0.
2. Commit mask=0x01, shift=0. Set tone0 on all lanes to 1000 and the other tones to 5000 -> each lane reads 1000 exactly 5 cycles after the first valid following the flush. phase_rst is high for exactly 1 cycle.
3. Commit mask=0xFF, shift=0, all tones 20000 -> lanes read 32767, sat_flag=1, sat_count +1 per valid cycle. Recommit with shift=3 -> lanes read 20000 and the count holds.
4. Mask=0xFF, all tones -32768: shift=3 -> -32768 with no saturation; shift=2 -> -32768 with saturation counted. Mask=0x03, tones 3 and -4, shift=1 -> -1 (floor), or 0 with TONE_COMBINER_ROUND_EN.
5. Issue cfg_stb mid-stream, then a second cfg_stb 2 cycles later -> two phase_rst pulses. Output is zero for 6 cycles after the second strobe while dac_valid tracks tone_valid.
6. Hold saturation continuously with sat_clr pulsed -> count reads 0 in the clr cycle, then increments. Preload 0xFFFF -> count holds at 0xFFFF. Assert reset mid-stream -> outputs go to 0 without waiting for clk.
